// File: rtl/sliding_detector_sched_pkg.sv
// Shared types and sizing helpers for the sliding-detector frame scheduler.
// Optional statistics counters are enabled by the SLIDING_DET_SCHED_STATS_EN macro.
package sliding_detector_sched_pkg;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} sched_state_t;

    function automatic int calc_num_pos(input int frame_len, input int seq_length);
        return frame_len - seq_length + 1;
    endfunction

    // Clamped to one bit so a single-position frame still has a legal index register.
    function automatic int calc_pos_w(input int num_pos);
        return (num_pos > 1) ? $clog2(num_pos) : 1;
    endfunction

endpackage

// File: rtl/sliding_detector_scheduler_window_mux.sv
// Combinational window select: picks SEQ_LENGTH consecutive samples/bits
// of the latched frame starting at index pos.
module sliding_window_mux
    import sliding_detector_sched_pkg::*;
#(
    parameter int FRAME_LEN          = 16,
    parameter int SEQ_LENGTH         = 3,
    parameter int EST_ERROR_BITWIDTH = 8,
    parameter int POS_W              = 4
) (
    input  logic signed [EST_ERROR_BITWIDTH-1:0] frame_resid [FRAME_LEN],
    input  logic        [FRAME_LEN-1:0]          frame_bits,
    input  logic        [POS_W-1:0]              pos,
    output logic signed [EST_ERROR_BITWIDTH-1:0] win_resid [SEQ_LENGTH],
    output logic        [SEQ_LENGTH-1:0]         win_bits
);

    always_comb begin
        for (int i = 0; i < SEQ_LENGTH; i++) begin
            win_resid[i] = '0;
            win_bits[i]  = 1'b0;
            // Guard keeps out-of-frame indices harmless; legal pos never reaches them.
            if (int'(pos) + i < FRAME_LEN) begin
                win_resid[i] = frame_resid[int'(pos) + i];
                win_bits[i]  = frame_bits[int'(pos) + i];
            end
        end
    end

endmodule

// File: rtl/sliding_detector_scheduler.sv
// Frame sequencer sharing one detector slice across all window positions of a frame.
// Optional per-flag result counters are enabled by the SLIDING_DET_SCHED_STATS_EN macro.
module sliding_detector_scheduler
    import sliding_detector_sched_pkg::*;
#(
    parameter  int FRAME_LEN            = 16,
    parameter  int SEQ_LENGTH           = 3,
    parameter  int NUM_OF_FLIP_PATTERNS = 4,
    parameter  int EST_ERROR_BITWIDTH   = 8,
    parameter  int ENER_BITWIDTH        = 18,
    localparam int NUM_POS              = calc_num_pos(FRAME_LEN, SEQ_LENGTH),
    localparam int POS_W                = calc_pos_w(NUM_POS),
    localparam int FLAG_W               = $clog2(NUM_OF_FLIP_PATTERNS + 1)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic signed [EST_ERROR_BITWIDTH-1:0] in_resid [FRAME_LEN],
    input  logic        [FRAME_LEN-1:0]          in_bits,
    output logic signed [EST_ERROR_BITWIDTH-1:0] slc_resid [SEQ_LENGTH],
    output logic        [SEQ_LENGTH-1:0]         slc_bits,
    input  logic        [FLAG_W-1:0]             slc_error_flag,
    input  logic        [ENER_BITWIDTH-1:0]      slc_mmse_val,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic        [POS_W-1:0]              out_pos,
    output logic        [FLAG_W-1:0]             out_flag,
    output logic        [ENER_BITWIDTH-1:0]      out_mmse,
    output logic                                 out_last,
    output logic                                 busy,
`ifdef SLIDING_DET_SCHED_STATS_EN
    input  logic                                 stat_clr,
    output logic        [15:0]                   stat_flag_cnt [NUM_OF_FLIP_PATTERNS+1],
`endif
    output sched_state_t                         fsm_state
);

    generate
        if (FRAME_LEN < SEQ_LENGTH) begin : g_bad_cfg
            $error("sliding_detector_scheduler: FRAME_LEN must be >= SEQ_LENGTH");
        end
    endgenerate

    localparam logic [POS_W-1:0] LAST_POS = POS_W'(NUM_POS - 1);

    sched_state_t                         state;
    logic        [POS_W-1:0]              pos;
    logic        [POS_W-1:0]              win_pos;
    logic signed [EST_ERROR_BITWIDTH-1:0] frame_resid [FRAME_LEN];
    logic        [FRAME_LEN-1:0]          frame_bits;
    logic                                 advance;

    // Both ports: a transfer happens on the clock edge where valid && ready;
    // the producer holds its payload stable from raising valid until that edge.
    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign fsm_state = state;
    assign advance   = !out_valid || out_ready;
    assign win_pos   = (state == SCAN) ? pos : '0;

    sliding_window_mux #(
        .FRAME_LEN          (FRAME_LEN),
        .SEQ_LENGTH         (SEQ_LENGTH),
        .EST_ERROR_BITWIDTH (EST_ERROR_BITWIDTH),
        .POS_W              (POS_W)
    ) u_window_mux (
        .frame_resid (frame_resid),
        .frame_bits  (frame_bits),
        .pos         (win_pos),
        .win_resid   (slc_resid),
        .win_bits    (slc_bits)
    );

    // Frame storage is deliberately unreset; it is only meaningful after an accept.
    always_ff @(posedge clk) begin
        if (!rst && state == IDLE && in_valid) begin
            frame_resid <= in_resid;
            frame_bits  <= in_bits;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pos       <= '0;
            out_valid <= 1'b0;
            out_pos   <= '0;
            out_flag  <= '0;
            out_mmse  <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        pos   <= '0;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (advance) begin
                        out_valid <= 1'b1;
                        out_pos   <= pos;
                        out_flag  <= slc_error_flag;
                        out_mmse  <= slc_mmse_val;
                        out_last  <= (pos == LAST_POS);
                        if (pos == LAST_POS) begin
                            state <= DRAIN;
                        end else begin
                            pos <= pos + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef SLIDING_DET_SCHED_STATS_EN
    logic out_fire;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk) begin
        for (int k = 0; k <= NUM_OF_FLIP_PATTERNS; k++) begin
            if (rst || stat_clr) begin
                stat_flag_cnt[k] <= '0;
            end else if (out_fire && out_flag == FLAG_W'(k) && stat_flag_cnt[k] != 16'hFFFF) begin
                stat_flag_cnt[k] <= stat_flag_cnt[k] + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sliding_detector_scheduler.sv
// Directed bench for sliding_detector_scheduler: a window-derived slice model, a per-position
// result table feeding an expected queue, and hand sequences for stalls, back-to-back and reset.
`timescale 1ns/1ps
module tb_sliding_detector_scheduler;
    import sliding_detector_sched_pkg::*;

    localparam int FRAME_LEN = 16;
    localparam int SEQ_LENGTH = 3;
    localparam int NFP = 4;
    localparam int EW = 8;
    localparam int MW = 18;
    localparam int NUM_POS = 14;
    localparam int POS_W = 4;
    localparam int FLAG_W = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic signed [EW-1:0]   in_resid [FRAME_LEN];
    logic [FRAME_LEN-1:0]   in_bits = '0;
    logic signed [EW-1:0]   slc_resid [SEQ_LENGTH];
    logic [SEQ_LENGTH-1:0]  slc_bits;
    logic [FLAG_W-1:0]      slc_error_flag;
    logic [MW-1:0]          slc_mmse_val;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [POS_W-1:0]       out_pos;
    logic [FLAG_W-1:0]      out_flag;
    logic [MW-1:0]          out_mmse;
    logic                   out_last;
    logic                   busy;
    sched_state_t           fsm_state;
`ifdef SLIDING_DET_SCHED_STATS_EN
    logic                   stat_clr = 1'b0;
    logic [15:0]            stat_flag_cnt [NFP+1];
`endif

    sliding_detector_scheduler dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_resid       (in_resid),
        .in_bits        (in_bits),
        .slc_resid      (slc_resid),
        .slc_bits       (slc_bits),
        .slc_error_flag (slc_error_flag),
        .slc_mmse_val   (slc_mmse_val),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pos        (out_pos),
        .out_flag       (out_flag),
        .out_mmse       (out_mmse),
        .out_last       (out_last),
        .busy           (busy),
`ifdef SLIDING_DET_SCHED_STATS_EN
        .stat_clr       (stat_clr),
        .stat_flag_cnt  (stat_flag_cnt),
`endif
        .fsm_state      (fsm_state)
    );

    // Slice model: frames carry resid[i] = i-8, so the window's first sample reveals its start index.
    int flag_mode = 0;
    always_comb begin
        int p;
        p = int'(slc_resid[0]) + 8;
        slc_error_flag = (flag_mode == 1) ? FLAG_W'(2) : FLAG_W'(p % 5);
        slc_mmse_val   = MW'(p * 16 + int'(slc_bits));
    end

    typedef struct packed {
        logic [POS_W-1:0]  pos;
        logic [FLAG_W-1:0] flag;
        logic [MW-1:0]     mmse;
        logic              last;
    } vec_t;

    vec_t vectors [NUM_POS];
    vec_t exp_q [$];
    int   n_vec = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_accept = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic load_exp(input logic [FRAME_LEN-1:0] bits);
        for (int p = 0; p < NUM_POS; p++) begin
            vectors[p].pos  = POS_W'(p);
            vectors[p].flag = (flag_mode == 1) ? FLAG_W'(2) : FLAG_W'(p % 5);
            vectors[p].mmse = MW'(p * 16 + int'((bits >> p) & 16'h7));
            vectors[p].last = (p == NUM_POS - 1);
            exp_q.push_back(vectors[p]);
        end
    endtask

    // One clock: score the transfer about to happen, step, then confirm stalled outputs held.
    task automatic cycle();
        vec_t held;
        vec_t want;
        logic stall;
        held.pos  = out_pos;
        held.flag = out_flag;
        held.mmse = out_mmse;
        held.last = out_last;
        stall = out_valid && !out_ready && !rst;
        if (out_valid && out_ready && !rst) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL extra_result: got pos=%0d, expected no result", out_pos);
            end else begin
                want = exp_q.pop_front();
                if (held !== want) begin
                    n_fail++;
                    $display("FAIL result: got pos=%0d flag=%0d mmse=%0d last=%0d, expected pos=%0d flag=%0d mmse=%0d last=%0d",
                             held.pos, held.flag, held.mmse, held.last, want.pos, want.flag, want.mmse, want.last);
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (stall && !rst) begin
            n_vec++;
            if (!out_valid || out_pos !== held.pos || out_flag !== held.flag ||
                out_mmse !== held.mmse || out_last !== held.last) begin
                n_fail++;
                $display("FAIL stall_hold: got valid=%0d pos=%0d flag=%0d, expected valid=1 pos=%0d flag=%0d",
                         out_valid, out_pos, out_flag, held.pos, held.flag);
            end
        end
    endtask

    task automatic run_frame(input logic [FRAME_LEN-1:0] bits, input logic [FRAME_LEN-1:0] bits_after,
                             input bit toggle, input bit keep_valid, input bit chk_win);
        int guard;
        int ready_err;
        logic [3:0] pat;
        pat = 4'b1001;
        load_exp(bits);
        in_bits  = bits;
        in_valid = 1'b1;
        out_ready = 1'b1;
        guard = 0;
        while (!in_ready && guard < 50) begin
            cycle();
            guard++;
        end
        check("accept_wait", int'(in_ready), 1);
        cycle();
        last_accept = cyc;
        if (keep_valid) in_bits = bits_after;
        else in_valid = 1'b0;
        check("busy_after_accept", int'(busy), 1);
        check("out_valid_after_accept", int'(out_valid), 0);
        guard = 0;
        ready_err = 0;
        while (exp_q.size() > 0 && guard < 200) begin
            out_ready = toggle ? pat[guard % 4] : 1'b1;
            if (guard == 1) check("first_result_latency", int'(out_valid), 1);
            if (chk_win && guard == 4) begin
                check("win_resid0", int'(slc_resid[0]), -4);
                check("win_resid1", int'(slc_resid[1]), -3);
                check("win_resid2", int'(slc_resid[2]), -2);
                check("win_bits", int'(slc_bits), int'(bits[6:4]));
            end
            if (in_ready) ready_err++;
            cycle();
            guard++;
        end
        check("results_outstanding", exp_q.size(), 0);
        check("in_ready_low_while_busy", ready_err, 0);
        check("busy_after_drain", int'(busy), 0);
        check("in_ready_after_drain", int'(in_ready), 1);
        exp_q.delete();
    endtask

    initial begin
        int first_accept;
        for (int i = 0; i < FRAME_LEN; i++) in_resid[i] = EW'(i - 8);

        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        check("rst_state", int'(fsm_state), int'(IDLE));
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_pos", int'(out_pos), 0);
        check("rst_out_flag", int'(out_flag), 0);
        check("rst_out_mmse", int'(out_mmse), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_in_ready", int'(in_ready), 1);

        // Free-flowing frame with window content checks at pos 4.
        run_frame(16'hA5C3, 16'h0000, 1'b0, 1'b0, 1'b1);

        // Backpressure pattern 1,0,0,1.
        run_frame(16'h3C96, 16'h0000, 1'b1, 1'b0, 1'b0);

        // in_valid held high across two frames; input changes during SCAN must be ignored.
        run_frame(16'h1234, 16'hEDCB, 1'b0, 1'b1, 1'b0);
        first_accept = last_accept;
        run_frame(16'hEDCB, 16'h0000, 1'b0, 1'b0, 1'b0);
        check("frame_period", last_accept - first_accept, NUM_POS + 2);

        // Reset while pos=7 with a result pending.
        load_exp(16'h5A5A);
        in_bits = 16'h5A5A;
        in_valid = 1'b1;
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        repeat (7) cycle();
        check("pre_abort_out_valid", int'(out_valid), 1);
        check("pre_abort_out_pos", int'(out_pos), 6);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        exp_q.delete();
        check("abort_state", int'(fsm_state), int'(IDLE));
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_in_ready", int'(in_ready), 1);
        check("abort_busy", int'(busy), 0);
        run_frame(16'h0F0F, 16'h0000, 1'b0, 1'b0, 1'b0);

`ifdef SLIDING_DET_SCHED_STATS_EN
        stat_clr = 1'b1;
        cycle();
        stat_clr = 1'b0;
        flag_mode = 1;
        run_frame(16'h1111, 16'h0000, 1'b0, 1'b0, 1'b0);
        run_frame(16'h2222, 16'h0000, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k <= NFP; k++)
            check($sformatf("stat_cnt_%0d", k), int'(stat_flag_cnt[k]), (k == 2) ? 2 * NUM_POS : 0);
        stat_clr = 1'b1;
        cycle();
        stat_clr = 1'b0;
        for (int k = 0; k <= NFP; k++)
            check($sformatf("stat_clr_%0d", k), int'(stat_flag_cnt[k]), 0);
        flag_mode = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
